fifo_uart_tx: RTL and testbench
===============================

# fifo_uart_tx

Serial transmitter that drains the 16-deep SRL16 byte FIFO. It watches the FIFO fill count, pops one byte whenever it is idle and the FIFO is non-empty, and shifts the byte out as an asynchronous serial frame on `tx`. It sits directly downstream of the FIFO, instantiated with `WIDTH = 8`, and uses the FIFO's fill count as its only "data available" indication.

## Interface
- `CLK_DIV`, default 434: clock cycles per bit period (434 gives 115200 baud at 50 MHz); legal range 2..65535.
- `PARITY`, default 0: 0 = none, 1 = even, 2 = odd.
- `STOP_BITS`, default 1: 1 or 2.

- `clk` in 1: the single clock; every register is clocked on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `fifo_data` in 8: FIFO output byte; combinationally valid whenever `fifo_fullness != 0`.
- `fifo_fullness` in 5: FIFO fill count, 0..16.
- `fifo_rd` out 1: one-cycle pop strobe to the FIFO.
- `tx` out 1: serial line; idles high.
- `busy` out 1: high from the pop cycle until the last stop bit ends.

## Operation
- Reset values: `tx` = 1, `fifo_rd` = 0, `busy` = 0, FSM in IDLE, baud counter 0, shift register 0.
- FSM states and transitions:
  - IDLE → LOAD when `fifo_fullness != 0`.
  - LOAD → START.
  - START → DATA.
  - DATA → PARITY when `PARITY != 0`, otherwise DATA → STOP.
  - PARITY → STOP.
  - STOP → IDLE.
- LOAD lasts one cycle:
  - `fifo_rd` = 1.
  - `fifo_data` is captured into the shift register at the same edge.
  - The parity accumulator is cleared to 0 for even parity, or set to 1 for odd parity.
- START: `tx` = 0 for one bit period.
- DATA: 8 bit periods, LSB first. Each bit is XORed into the parity accumulator.
- PARITY: one bit period; `tx` = accumulator.
- STOP: `tx` = 1 for `STOP_BITS` bit periods.
- `fifo_rd` is asserted only in LOAD. It is never asserted when `fifo_fullness == 0`.
- At most one pop per frame.
- A FIFO write in the same cycle as `fifo_rd` is legal. The data is captured before the edge, so the captured byte is the oldest entry.
- The design never pops while a frame is in flight. Bytes arriving mid-frame wait in the FIFO; overflow at 16 entries is the producer's responsibility.

## Timing
- Baud counter width is 16 bits. It counts 0..`CLK_DIV`-1 and wraps to 0. The wrap pulse (`tick`) ends each bit.
- The counter is held at 0 in IDLE and LOAD, and starts counting on entry to START.
- Frame length in clocks is `CLK_DIV` × (1 + 8 + (`PARITY != 0`) + `STOP_BITS`).
- Latency:
  - FIFO goes non-empty in cycle N → `fifo_rd` high in cycle N+1.
  - `tx` falls in cycle N+2.
- `busy` rises with `fifo_rd` and falls on the cycle the FSM returns to IDLE.
- Back-to-back frames: if the FIFO is non-empty at STOP end, the next LOAD follows immediately. The inter-frame gap is exactly 1 clock (the LOAD cycle), with `tx` held high.
- `tx` is a registered output, so it has no combinational glitches.
- Reset asserted mid-frame:
  - `tx` returns to 1 and `fifo_rd` to 0 immediately.
  - The partial frame is abandoned and the popped byte is lost.
  - After release, operation resumes from IDLE on the next rising edge.

## Structure
- Shared package `gd_uart_pkg` holds:
  - the FSM state enum (IDLE, LOAD, START, DATA, PARITY, STOP);
  - parity mode constants `PAR_NONE`/`PAR_EVEN`/`PAR_ODD`;
  - the default `CLK_DIV` constant.
- One sub-module, `baud_gen`:
  - ports `clk`, `rst`, `en`, `tick`, with parameter `CLK_DIV`;
  - holds the 16-bit counter.
- Bit index (3 bits) and stop-bit counter (1 bit) stay in `fifo_uart_tx`.

## Test plan
- Single byte: `CLK_DIV`=4, `PARITY`=0, FIFO preloaded with 0x55 →
  - one `fifo_rd` pulse;
  - `tx` sequence 0,1,0,1,0,1,0,1,0,1, 4 clocks per bit;
  - `busy` high for 41 clocks.
- Burst: 3 bytes 0xA5, 0x00, 0xFF written in consecutive cycles → three frames in write order, separated by 1-clock high gaps; exactly 3 `fifo_rd` pulses.
- Parity and stop bits: `PARITY`=2, `STOP_BITS`=2, byte 0x07 (three ones) → parity bit 0; frame is 12 bits = 48 clocks.
- Empty FIFO: `fifo_fullness` held at 0 for 1000 cycles → `fifo_rd` and `busy` stay 0, `tx` stays 1.
- Simultaneous write and pop: FIFO holds 0x11, and 0x22 is written in the LOAD cycle → first frame carries 0x11, second carries 0x22, and fullness ends at 0.
- Reset mid-frame: assert `rst` during data bit 3 → `tx` = 1 within the same cycle with no clock edge needed; after release, the next queued byte is sent with a full start bit.

Source files
------------

// File: rtl/gd_uart_pkg.sv
// Shared definitions for the FIFO-draining UART transmitter: FSM states,
// parity modes and the default baud divider.
package gd_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  // 50 MHz / 115200 baud
  localparam int unsigned DEFAULT_CLK_DIV = 434;

  // Starting value of the running parity accumulator for a given mode.
  function automatic logic parity_seed(input int unsigned mode);
    return (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Bit-period timer: a 16-bit counter that runs 0..CLK_DIV-1 while enabled
// and pulses tick on the last count of each bit period.
module baud_gen
  import gd_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam logic [15:0] LAST = 16'(CLK_DIV - 1);

  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (which would infer a latch).
  always_comb begin
    cnt_d = cnt_q;
    if (!en || (cnt_q == LAST)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign tick = en && (cnt_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial transmitter that pops bytes from the upstream byte FIFO whenever it
// is idle and the FIFO is non-empty, and shifts each out as an async frame.
module fifo_uart_tx
  import gd_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV   = DEFAULT_CLK_DIV,
  parameter int unsigned PARITY    = PAR_NONE,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] fifo_data,
  input  logic [4:0] fifo_fullness,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy
);

  localparam logic HAS_PARITY = (PARITY != PAR_NONE);
  localparam logic PAR_INIT   = parity_seed(PARITY);
  localparam logic LAST_STOP  = (STOP_BITS == 2);

  state_e     state_q;
  logic [7:0] shift_q;
  logic [2:0] bit_idx_q;
  logic       stop_q;
  logic       par_q;
  logic       tx_q;
  logic       rd_q;
  logic       busy_q;

  logic fifo_avail;
  logic baud_en;
  logic tick;

  assign fifo_avail = (fifo_fullness != 5'd0);

  // The bit timer is parked at zero until the start bit begins.
  assign baud_en = (state_q != ST_IDLE) && (state_q != ST_LOAD);

  baud_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_baud_gen (
    .clk (clk),
    .rst (rst),
    .en  (baud_en),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      stop_q    <= 1'b0;
      par_q     <= 1'b0;
      tx_q      <= 1'b1;
      rd_q      <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      rd_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fifo_avail) begin
            state_q <= ST_LOAD;
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        // fifo_data is still the head entry here; the pop takes effect at this edge.
        ST_LOAD: begin
          shift_q   <= fifo_data;
          par_q     <= PAR_INIT;
          bit_idx_q <= '0;
          stop_q    <= 1'b0;
          tx_q      <= 1'b0;
          state_q   <= ST_START;
        end
        ST_START: begin
          if (tick) begin
            tx_q    <= shift_q[0];
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (tick) begin
            par_q     <= par_q ^ shift_q[0];
            shift_q   <= {1'b0, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              if (HAS_PARITY) begin
                tx_q    <= par_q ^ shift_q[0];
                state_q <= ST_PARITY;
              end else begin
                tx_q    <= 1'b1;
                state_q <= ST_STOP;
              end
            end else begin
              tx_q <= shift_q[1];
            end
          end
        end
        ST_PARITY: begin
          if (tick) begin
            tx_q    <= 1'b1;
            state_q <= ST_STOP;
          end
        end
        // Going straight to LOAD keeps the inter-frame gap at one clock.
        ST_STOP: begin
          if (tick) begin
            if (stop_q == LAST_STOP) begin
              stop_q <= 1'b0;
              if (fifo_avail) begin
                state_q <= ST_LOAD;
                rd_q    <= 1'b1;
              end else begin
                state_q <= ST_IDLE;
                busy_q  <= 1'b0;
              end
            end else begin
              stop_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign tx      = tx_q;
  assign fifo_rd = rd_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: two instances (8N1 and 8O2, CLK_DIV=4),
// each fed by a small behavioural FIFO.
module tb_fifo_uart_tx;
  import gd_uart_pkg::*;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0] fifo_data0, fifo_data1;
  logic [4:0] cnt0, cnt1;
  logic       fifo_rd0, fifo_rd1, tx0, tx1, busy0, busy1;

  logic [7:0] mem0 [16];
  logic [7:0] mem1 [16];
  logic [3:0] wp0, rp0, wp1, rp1;
  logic       push0, push1, flush;
  logic [7:0] pdata0, pdata1;
  int         rd_cnt0, rd_cnt1, bad_pop;

  int vectors = 0;
  int miscompares = 0;

  fifo_uart_tx #(.CLK_DIV(DIV), .PARITY(PAR_NONE), .STOP_BITS(1)) dut0 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data0), .fifo_fullness(cnt0),
    .fifo_rd(fifo_rd0), .tx(tx0), .busy(busy0)
  );

  fifo_uart_tx #(.CLK_DIV(DIV), .PARITY(PAR_ODD), .STOP_BITS(2)) dut1 (
    .clk(clk), .rst(rst), .fifo_data(fifo_data1), .fifo_fullness(cnt1),
    .fifo_rd(fifo_rd1), .tx(tx1), .busy(busy1)
  );

  assign fifo_data0 = mem0[rp0];
  assign fifo_data1 = mem1[rp1];

  always @(posedge clk) begin
    if (flush) begin
      wp0 <= '0; rp0 <= '0; cnt0 <= '0; rd_cnt0 <= 0;
      wp1 <= '0; rp1 <= '0; cnt1 <= '0; rd_cnt1 <= 0;
      bad_pop <= 0;
    end else begin
      if (push0) begin mem0[wp0] <= pdata0; wp0 <= wp0 + 4'd1; end
      if (push1) begin mem1[wp1] <= pdata1; wp1 <= wp1 + 4'd1; end
      if (fifo_rd0) begin rp0 <= rp0 + 4'd1; rd_cnt0 <= rd_cnt0 + 1; end
      if (fifo_rd1) begin rp1 <= rp1 + 4'd1; rd_cnt1 <= rd_cnt1 + 1; end
      if ((fifo_rd0 && cnt0 == 5'd0) || (fifo_rd1 && cnt1 == 5'd0)) bad_pop <= bad_pop + 1;
      cnt0 <= cnt0 + {4'b0, push0} - {4'b0, fifo_rd0};
      cnt1 <= cnt1 + {4'b0, push1} - {4'b0, fifo_rd1};
    end
  end

  function automatic logic tx_of(input int sel);
    return (sel != 0) ? tx1 : tx0;
  endfunction
  function automatic logic rd_of(input int sel);
    return (sel != 0) ? fifo_rd1 : fifo_rd0;
  endfunction
  function automatic logic busy_of(input int sel);
    return (sel != 0) ? busy1 : busy0;
  endfunction

  // Entered at the negedge of a LOAD cycle; walks the whole frame clock by clock.
  task automatic run_frame(input int sel, input logic [7:0] b, input int par, input int stops);
    logic [11:0] bits;
    int nb;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1 + i] = b[i];
    nb = 9;
    if (par != 0) begin
      bits[nb] = (par == int'(PAR_ODD)) ? ~(^b) : (^b);
      nb++;
    end
    nb = nb + stops;
    vectors++;
    if (rd_of(sel) !== 1'b1 || busy_of(sel) !== 1'b1 || tx_of(sel) !== 1'b1) begin
      miscompares++;
      $display("FAIL load_%0d byte=%02h: rd=%b busy=%b tx=%b, required 1 1 1",
               sel, b, rd_of(sel), busy_of(sel), tx_of(sel));
    end
    for (int c = 0; c < nb * DIV; c++) begin
      @(negedge clk);
      push0 = 1'b0;
      push1 = 1'b0;
      vectors++;
      if (tx_of(sel) !== bits[c / DIV] || busy_of(sel) !== 1'b1 || rd_of(sel) !== 1'b0) begin
        miscompares++;
        $display("FAIL frame_%0d byte=%02h clk=%0d: tx=%b busy=%b rd=%b, required %b 1 0",
                 sel, b, c, tx_of(sel), busy_of(sel), rd_of(sel), bits[c / DIV]);
      end
    end
  endtask

  task automatic wait_load(input int sel);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (rd_of(sel) === 1'b1) ok = 1'b1;
      else begin
        @(negedge clk);
        push0 = 1'b0;
        push1 = 1'b0;
      end
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL wait_load_%0d: no fifo_rd within 100 cycles, required a pop", sel);
    end
  endtask

  task automatic expect_idle(input int sel, input string name);
    vectors++;
    if (busy_of(sel) !== 1'b0 || tx_of(sel) !== 1'b1 || rd_of(sel) !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy=%b tx=%b rd=%b, required 0 1 0",
               name, busy_of(sel), tx_of(sel), rd_of(sel));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b1; push0 = 1'b0; push1 = 1'b0; pdata0 = '0; pdata1 = '0;
    repeat (3) @(negedge clk);
    expect_idle(0, "reset_dut0");
    expect_idle(1, "reset_dut1");
    rst = 1'b0;
    flush = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_byte();
    int base = rd_cnt0;
    pdata0 = 8'h55; push0 = 1'b1;
    @(negedge clk);
    push0 = 1'b0;
    vectors++;
    if (fifo_rd0 !== 1'b0 || busy0 !== 1'b0) begin
      miscompares++;
      $display("FAIL latency_n: rd=%b busy=%b, required 0 0", fifo_rd0, busy0);
    end
    @(negedge clk);
    vectors++;
    if (fifo_rd0 !== 1'b1) begin
      miscompares++;
      $display("FAIL latency_n1: rd=%b, required 1", fifo_rd0);
    end
    run_frame(0, 8'h55, 0, 1);
    @(negedge clk);
    expect_idle(0, "single_end");
    vectors++;
    if (rd_cnt0 - base !== 1 || cnt0 !== 5'd0) begin
      miscompares++;
      $display("FAIL single_pops: pops=%0d fullness=%0d, required 1 0", rd_cnt0 - base, cnt0);
    end
  endtask

  task automatic test_back_to_back();
    int base = rd_cnt0;
    pdata0 = 8'hA5; push0 = 1'b1;
    @(negedge clk);
    pdata0 = 8'h00;
    @(negedge clk);
    pdata0 = 8'hFF;
    run_frame(0, 8'hA5, 0, 1);
    @(negedge clk);
    run_frame(0, 8'h00, 0, 1);
    @(negedge clk);
    run_frame(0, 8'hFF, 0, 1);
    @(negedge clk);
    expect_idle(0, "burst_end");
    vectors++;
    if (rd_cnt0 - base !== 3 || cnt0 !== 5'd0) begin
      miscompares++;
      $display("FAIL burst_pops: pops=%0d fullness=%0d, required 3 0", rd_cnt0 - base, cnt0);
    end
  endtask

  task automatic test_parity_stop();
    pdata1 = 8'h07; push1 = 1'b1;
    @(negedge clk);
    push1 = 1'b0;
    wait_load(1);
    run_frame(1, 8'h07, int'(PAR_ODD), 2);
    @(negedge clk);
    expect_idle(1, "parity_end");
  endtask

  task automatic test_empty();
    int bad = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      vectors++;
      if (fifo_rd0 !== 1'b0 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
        miscompares++;
        bad++;
        if (bad < 4) $display("FAIL empty cyc=%0d: rd=%b busy=%b tx=%b, required 0 0 1",
                              i, fifo_rd0, busy0, tx0);
      end
    end
  endtask

  task automatic test_write_during_pop();
    pdata0 = 8'h11; push0 = 1'b1;
    @(negedge clk);
    push0 = 1'b0;
    @(negedge clk);
    pdata0 = 8'h22; push0 = 1'b1;
    run_frame(0, 8'h11, 0, 1);
    @(negedge clk);
    run_frame(0, 8'h22, 0, 1);
    @(negedge clk);
    expect_idle(0, "simul_end");
    vectors++;
    if (cnt0 !== 5'd0) begin
      miscompares++;
      $display("FAIL simul_fullness: fullness=%0d, required 0", cnt0);
    end
  endtask

  task automatic test_reset_mid_frame();
    pdata0 = 8'hF0; push0 = 1'b1;
    @(negedge clk);
    pdata0 = 8'h5A;
    @(negedge clk);
    push0 = 1'b0;
    // Frame clock 18 sits in the middle of data bit 3, which is 0 for 0xF0.
    repeat (18) @(negedge clk);
    vectors++;
    if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_bit3: tx=%b busy=%b, required 0 1", tx0, busy0);
    end
    rst = 1'b1;
    #1;
    expect_idle(0, "async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_load(0);
    run_frame(0, 8'h5A, 0, 1);
    @(negedge clk);
    expect_idle(0, "after_reset_end");
    vectors++;
    if (cnt0 !== 5'd0 || bad_pop !== 0) begin
      miscompares++;
      $display("FAIL pop_accounting: fullness=%0d empty_pops=%0d, required 0 0", cnt0, bad_pop);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_parity_stop();
    test_empty();
    test_write_during_pop();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
